bch_decoder: RTL and testbench

BCH_DECODER -- requirements
Module: bch_decoder

---
 rtl/bch_pkg.sv | 72 +++++++
 rtl/bch_decoder_gf_mul.sv | 24 ++
 rtl/bch_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_bch_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared encodings, field constants and GF(2^m) helpers for the t=2 binary BCH decoder.
package bch_pkg;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_63   = 2'd1;
    localparam logic [1:0] CODE_255  = 2'd2;
    localparam logic [1:0] CODE_1023 = 2'd3;

    localparam logic MODE_HARD = 1'b0;
    localparam logic MODE_SOFT = 1'b1;

    localparam logic [9:0] NO_LOC = 10'd1023;

    // Primitive polynomials including the x^m term.
    localparam logic [10:0] POLY6  = 11'h043;
    localparam logic [10:0] POLY8  = 11'h11D;
    localparam logic [10:0] POLY10 = 11'h409;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KES,
        ST_CHIEN,
        ST_OUT
    } state_t;

    function automatic logic [9:0] code_n(input logic [1:0] c);
        case (c)
            CODE_63:  return 10'd63;
            CODE_255: return 10'd255;
            default:  return 10'd1023;
        endcase
    endfunction

    function automatic logic [7:0] code_words(input logic [1:0] c, input logic m);
        logic [7:0] w;
        case (c)
            CODE_63:  w = 8'd1;
            CODE_255: w = 8'd4;
            default:  w = 8'd16;
        endcase
        return (m == MODE_SOFT) ? (w << 3) : w;
    endfunction

    function automatic logic [10:0] poly_of(input logic [1:0] c);
        case (c)
            CODE_63:  return POLY6;
            CODE_255: return POLY8;
            default:  return POLY10;
        endcase
    endfunction

    function automatic logic [9:0] mul_alpha(input logic [9:0] v, input logic [1:0] c);
        logic [10:0] t;
        t = {v, 1'b0};
        case (c)
            CODE_63:  if (t[6])  t = t ^ POLY6;
            CODE_255: if (t[8])  t = t ^ POLY8;
            default:  if (t[10]) t = t ^ POLY10;
        endcase
        return t[9:0];
    endfunction

    // Multiply by alpha^-1: fold in the polynomial when the constant term is set, then shift down.
    function automatic logic [9:0] div_alpha(input logic [9:0] v, input logic [1:0] c);
        logic [10:0] t;
        t = {1'b0, v};
        if (t[0]) t = t ^ poly_of(c);
        return t[10:1];
    endfunction

endpackage

// File: rtl/bch_decoder_gf_mul.sv
// Combinational GF(2^M) multiplier reducing modulo the field's primitive polynomial.
module gf_mul #(
    parameter int M = 6
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] p_o
);
    import bch_pkg::*;

    localparam logic [10:0]  POLY = (M == 6) ? POLY6 : (M == 8) ? POLY8 : POLY10;
    localparam logic [M-1:0] RED  = POLY[M-1:0];

    logic [M-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? RED : '0) ^ (b_i[i] ? a_i : '0);
        end
        p_o = acc;
    end

endmodule

// File: rtl/bch_decoder.sv
// t=2 binary BCH decoder for n = 63/255/1023: streaming syndromes, one-cycle
// inversion-free key equation, bit-serial Chien search, ascending location output.
module bch_decoder
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        mode,
    input  logic [1:0]  code,
    input  logic        set,
    input  logic [63:0] idata,
    output logic        ready,
    output logic        finish,
    output logic [9:0]  odata
);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  s1_q, s1_d, s3_q, s3_d;
    logic [9:0]  t1_q, t1_d, t2_q, t2_d;
    logic        v2_q, v2_d;
    logic [9:0]  pos_q, pos_d;
    logic [1:0]  nroot_q, nroot_d;
    logic [9:0]  loc0_q, loc0_d, loc1_q, loc1_d;
    logic        two_q, two_d, oidx_q, oidx_d;
    logic        ready_q, ready_d, finish_q, finish_d;
    logic [9:0]  odata_q, odata_d;

    logic [9:0]  acc1, acc3, sq, cu;
    logic [63:0] sh;
    logic        bit_c;
    logic [1:0]  nr_c;
    logic [5:0]  sq6, cu6;
    logic [7:0]  sq8, cu8;
    logic [9:0]  sq10, cu10;

    assign ready  = ready_q;
    assign finish = finish_q;
    assign odata  = odata_q;

    gf_mul #(.M(6))  u_sq6  (.a_i(s1_q[5:0]), .b_i(s1_q[5:0]), .p_o(sq6));
    gf_mul #(.M(6))  u_cu6  (.a_i(sq6),       .b_i(s1_q[5:0]), .p_o(cu6));
    gf_mul #(.M(8))  u_sq8  (.a_i(s1_q[7:0]), .b_i(s1_q[7:0]), .p_o(sq8));
    gf_mul #(.M(8))  u_cu8  (.a_i(sq8),       .b_i(s1_q[7:0]), .p_o(cu8));
    gf_mul #(.M(10)) u_sq10 (.a_i(s1_q),      .b_i(s1_q),      .p_o(sq10));
    gf_mul #(.M(10)) u_cu10 (.a_i(sq10),      .b_i(s1_q),      .p_o(cu10));

    always_comb begin
        case (code_q)
            CODE_63:  begin sq = {4'd0, sq6}; cu = {4'd0, cu6}; end
            CODE_255: begin sq = {2'd0, sq8}; cu = {2'd0, cu8}; end
            default:  begin sq = sq10;        cu = cu10;        end
        endcase
    end

    // Horner over one word; soft mode uses only the sign bit of each byte, and the
    // very first symbol of the codeword is padding.
    always_comb begin
        acc1  = s1_q;
        acc3  = s3_q;
        sh    = idata;
        bit_c = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (mode_q == MODE_HARD || (k % 8) == 0) begin
                bit_c = sh[63] && !(cnt_q == 8'd0 && k == 0);
                acc1  = mul_alpha(acc1, code_q) ^ {9'd0, bit_c};
                acc3  = mul_alpha(mul_alpha(mul_alpha(acc3, code_q), code_q), code_q) ^ {9'd0, bit_c};
            end
            sh = sh << 1;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        s1_d     = s1_q;
        s3_d     = s3_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        v2_d     = v2_q;
        pos_d    = pos_q;
        nroot_d  = nroot_q;
        loc0_d   = loc0_q;
        loc1_d   = loc1_q;
        two_d    = two_q;
        oidx_d   = oidx_q;
        ready_d  = 1'b0;
        finish_d = 1'b0;
        odata_d  = '0;
        nr_c     = nroot_q;
        case (state_q)
            ST_IDLE: begin
                if (set && code != CODE_NONE) begin
                    mode_d  = mode;
                    code_d  = code;
                    s1_d    = '0;
                    s3_d    = '0;
                    cnt_d   = '0;
                    loc0_d  = '0;
                    loc1_d  = '0;
                    nroot_d = '0;
                    ready_d = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s1_d  = acc1;
                s3_d  = acc3;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == code_words(code_q, mode_q) - 8'd1) state_d = ST_KES;
                else ready_d = 1'b1;
            end
            ST_KES: begin
                // S1=0 covers both the clean word and the uncorrectable S1=0,S3!=0 case.
                if (s1_q == '0) begin
                    two_d    = 1'b0;
                    oidx_d   = 1'b0;
                    loc0_d   = NO_LOC;
                    finish_d = 1'b1;
                    odata_d  = NO_LOC;
                    state_d  = ST_OUT;
                end else begin
                    t1_d    = sq;
                    t2_d    = s3_q ^ cu;
                    v2_d    = (s3_q != cu);
                    pos_d   = '0;
                    nroot_d = '0;
                    state_d = ST_CHIEN;
                end
            end
            ST_CHIEN: begin
                if ((s1_q ^ t1_q ^ t2_q) == '0) begin
                    if (nroot_q == 2'd0) loc0_d = pos_q;
                    if (nroot_q == 2'd1) loc1_d = pos_q;
                    if (nroot_q != 2'd3) nr_c = nroot_q + 2'd1;
                end
                nroot_d = nr_c;
                t1_d    = div_alpha(t1_q, code_q);
                t2_d    = div_alpha(div_alpha(t2_q, code_q), code_q);
                pos_d   = pos_q + 10'd1;
                if (pos_q == code_n(code_q) - 10'd1) begin
                    state_d  = ST_OUT;
                    finish_d = 1'b1;
                    oidx_d   = 1'b0;
                    if (nr_c == (v2_q ? 2'd2 : 2'd1)) begin
                        two_d   = v2_q;
                        odata_d = loc0_d;
                    end else begin
                        two_d   = 1'b0;
                        loc0_d  = NO_LOC;
                        odata_d = NO_LOC;
                    end
                end
            end
            ST_OUT: begin
                if (oidx_q != two_q) begin
                    oidx_d   = 1'b1;
                    finish_d = 1'b1;
                    odata_d  = loc1_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_HARD;
            code_q   <= CODE_NONE;
            cnt_q    <= '0;
            s1_q     <= '0;
            s3_q     <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            v2_q     <= 1'b0;
            pos_q    <= '0;
            nroot_q  <= '0;
            loc0_q   <= '0;
            loc1_q   <= '0;
            two_q    <= 1'b0;
            oidx_q   <= 1'b0;
            ready_q  <= 1'b0;
            finish_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            s1_q     <= s1_d;
            s3_q     <= s3_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            v2_q     <= v2_d;
            pos_q    <= pos_d;
            nroot_q  <= nroot_d;
            loc0_q   <= loc0_d;
            loc1_q   <= loc1_d;
            two_q    <= two_d;
            oidx_q   <= oidx_d;
            ready_q  <= ready_d;
            finish_q <= finish_d;
            odata_q  <= odata_d;
        end
    end

endmodule

// File: tb/tb_bch_decoder.sv
// Directed bench for bch_decoder: known error patterns per code/mode with hand-derived locations.
module tb_bch_decoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mode;
    logic [1:0]  code;
    logic        set;
    logic [63:0] idata;
    logic        ready;
    logic        finish;
    logic [9:0]  odata;

    always #5 clk = ~clk;

    bch_decoder dut (
        .clk    (clk),
        .rstn   (rstn),
        .mode   (mode),
        .code   (code),
        .set    (set),
        .idata  (idata),
        .ready  (ready),
        .finish (finish),
        .odata  (odata)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] wbuf [0:127];
    int          nrdy, nfin, lat, overlap;
    bit          tmo;
    bit          inject = 1'b0;
    logic [9:0]  fo [0:3];

    task automatic fill_buf(input logic [63:0] v);
        for (int i = 0; i < 128; i++) wbuf[i] = v;
    endtask

    // r_j of a hard codeword of w words sits in word w-1-j/64, bit j%64.
    task automatic flip_hard(input int j, input int w);
        wbuf[w-1-j/64][j%64] = ~wbuf[w-1-j/64][j%64];
    endtask

    // LLR of r_j for a soft codeword of w words sits in word w-1-j/8, byte j%8 from the bottom.
    task automatic put_llr(input int j, input int w, input logic [7:0] v);
        wbuf[w-1-j/8][8*(j%8) +: 8] = v;
    endtask

    task automatic do_decode(input logic [1:0] c, input logic m);
        int  cyc;
        bit  done;
        nrdy = 0; nfin = 0; lat = -1; overlap = 0; tmo = 1'b1;
        for (int i = 0; i < 4; i++) fo[i] = '0;
        @(negedge clk);
        code = c; mode = m; set = 1'b1; idata = '0;
        @(negedge clk);
        set  = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 1400) begin
            if (inject && cyc == 2) begin
                set = 1'b1; code = 2'd2; mode = 1'b1;
            end else begin
                set = 1'b0;
            end
            if (ready && finish) overlap++;
            if (ready) begin
                idata = (nrdy < 128) ? wbuf[nrdy] : '0;
                nrdy++;
            end
            if (finish) begin
                if (lat < 0) lat = cyc;
                if (nfin < 4) fo[nfin] = odata;
                nfin++;
            end else if (nfin > 0) begin
                tmo  = 1'b0;
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        set = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; set = 1'b0; code = 2'd0; mode = 1'b0; idata = '0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", finish); end
        total++; if (odata !== 10'd0) begin bad++; $display("FAIL reset_odata got=%0d want=0", odata); end
        rstn = 1'b0;
    endtask

    task automatic test_code0_ignored();
        int act;
        act = 0;
        @(negedge clk); code = 2'd0; mode = 1'b0; set = 1'b1;
        @(negedge clk); set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ready || finish) act++;
            @(negedge clk);
        end
        total++; if (act != 0) begin bad++; $display("FAIL code0_activity got=%0d want=0", act); end
    endtask

    task automatic test_two_err_63();
        fill_buf('0); flip_hard(5, 1); flip_hard(40, 1);
        do_decode(2'd1, 1'b0);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL two63_timeout got=%0d want=0", tmo); end
        total++; if (nrdy != 1) begin bad++; $display("FAIL two63_ready_cycles got=%0d want=1", nrdy); end
        total++; if (nfin != 2) begin bad++; $display("FAIL two63_finish_cycles got=%0d want=2", nfin); end
        total++; if (fo[0] !== 10'd5) begin bad++; $display("FAIL two63_loc0 got=%0d want=5", fo[0]); end
        total++; if (fo[1] !== 10'd40) begin bad++; $display("FAIL two63_loc1 got=%0d want=40", fo[1]); end
        total++; if (overlap != 0) begin bad++; $display("FAIL two63_overlap got=%0d want=0", overlap); end
        total++; if (lat < 0 || lat > 1 + 63 + 3) begin bad++; $display("FAIL two63_latency got=%0d want<=67", lat); end
    endtask

    task automatic test_single_62_pad();
        fill_buf('0);
        wbuf[0] = 64'hC000_0000_0000_0000;  // padding bit set plus r_62
        do_decode(2'd1, 1'b0);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL one62_timeout got=%0d want=0", tmo); end
        total++; if (nfin != 1) begin bad++; $display("FAIL one62_finish_cycles got=%0d want=1", nfin); end
        total++; if (fo[0] !== 10'd62) begin bad++; $display("FAIL one62_loc got=%0d want=62", fo[0]); end
    endtask

    task automatic test_clean_255();
        fill_buf(64'hFFFF_FFFF_FFFF_FFFF);  // all-ones word is a codeword; padding bit also 1
        do_decode(2'd2, 1'b0);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL clean255_timeout got=%0d want=0", tmo); end
        total++; if (nrdy != 4) begin bad++; $display("FAIL clean255_ready_cycles got=%0d want=4", nrdy); end
        total++; if (nfin != 1) begin bad++; $display("FAIL clean255_finish_cycles got=%0d want=1", nfin); end
        total++; if (fo[0] !== 10'd1023) begin bad++; $display("FAIL clean255_odata got=%0d want=1023", fo[0]); end
    endtask

    task automatic test_uncorr_255();
        // alpha^0 + alpha^85 + alpha^170 = 0 (the GF(4) subfield), cube sum = 1.
        fill_buf('0); flip_hard(0, 4); flip_hard(85, 4); flip_hard(170, 4);
        do_decode(2'd2, 1'b0);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL unc255_timeout got=%0d want=0", tmo); end
        total++; if (nfin != 1) begin bad++; $display("FAIL unc255_finish_cycles got=%0d want=1", nfin); end
        total++; if (fo[0] !== 10'd1023) begin bad++; $display("FAIL unc255_odata got=%0d want=1023", fo[0]); end
    endtask

    task automatic test_soft_1023();
        fill_buf(64'h1414_1414_1414_1414);
        put_llr(0, 128, 8'hEC);
        put_llr(1022, 128, 8'hEC);
        do_decode(2'd3, 1'b1);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL soft1023_timeout got=%0d want=0", tmo); end
        total++; if (nrdy != 128) begin bad++; $display("FAIL soft1023_ready_cycles got=%0d want=128", nrdy); end
        total++; if (nfin != 2) begin bad++; $display("FAIL soft1023_finish_cycles got=%0d want=2", nfin); end
        total++; if (fo[0] !== 10'd0) begin bad++; $display("FAIL soft1023_loc0 got=%0d want=0", fo[0]); end
        total++; if (fo[1] !== 10'd1022) begin bad++; $display("FAIL soft1023_loc1 got=%0d want=1022", fo[1]); end
        total++; if (lat < 0 || lat > 128 + 1023 + 3) begin bad++; $display("FAIL soft1023_latency got=%0d want<=1154", lat); end
        total++; if (overlap != 0) begin bad++; $display("FAIL soft1023_overlap got=%0d want=0", overlap); end
    endtask

    task automatic test_reset_in_load();
        int act;
        fill_buf(64'h0123_4567_89AB_CDEF);
        @(negedge clk); code = 2'd3; mode = 1'b0; set = 1'b1;
        @(negedge clk); set = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstload_in_load got=%b want=1", ready); end
        #2 rstn = 1'b1;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstload_ready got=%b want=0", ready); end
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL rstload_finish got=%b want=0", finish); end
        @(negedge clk); rstn = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready || finish) act++;
            @(negedge clk);
        end
        total++; if (act != 0) begin bad++; $display("FAIL rstload_quiet got=%0d want=0", act); end
        fill_buf('0); flip_hard(1, 1); flip_hard(33, 1);
        do_decode(2'd1, 1'b0);
        total++; if (nfin != 2) begin bad++; $display("FAIL rstload_after_finish got=%0d want=2", nfin); end
        total++; if (fo[0] !== 10'd1) begin bad++; $display("FAIL rstload_after_loc0 got=%0d want=1", fo[0]); end
        total++; if (fo[1] !== 10'd33) begin bad++; $display("FAIL rstload_after_loc1 got=%0d want=33", fo[1]); end
    endtask

    task automatic test_set_while_busy();
        fill_buf('0); flip_hard(0, 1);
        inject = 1'b1;
        do_decode(2'd1, 1'b0);
        inject = 1'b0;
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL busyset_timeout got=%0d want=0", tmo); end
        total++; if (nfin != 1) begin bad++; $display("FAIL busyset_finish_cycles got=%0d want=1", nfin); end
        total++; if (fo[0] !== 10'd0) begin bad++; $display("FAIL busyset_loc got=%0d want=0", fo[0]); end
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL busyset_no_restart got=%b want=0", ready); end
    endtask

    initial begin
        test_reset();
        test_code0_ignored();
        test_two_err_63();
        test_single_62_pad();
        test_clean_255();
        test_uncorr_255();
        test_soft_1023();
        test_reset_in_load();
        test_set_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
